// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported synchronous memory.
// Port 0 is the read-only instruction-fetch requester. Port 1 is the load/store requester.
// Each grant runs IDLE -> ACCESS -> RESP -> IDLE. Every output comes straight from a register.
module mem_arbiter #(
  parameter int unsigned WORDS      = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  // instruction-fetch port (port 0)
  input  logic                  if_req_i,
  input  logic [WORDS-1:0]      if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_data_o,
  // load/store port (port 1)
  input  logic                  dt_req_i,
  input  logic                  dt_we_i,
  input  logic [WORDS-1:0]      dt_addr_i,
  input  logic [DATA_WIDTH-1:0] dt_data_i,
  output logic                  dt_ack_o,
  output logic [DATA_WIDTH-1:0] dt_data_o,
  // shared memory
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wr_o,
  output logic                  mem_rd_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q;
  logic                  last_grant_q;  // 0 = port 0 granted last, 1 = port 1
  logic                  grant_q;       // port owning the current transfer
  logic                  we_q;
  logic [WORDS-1:0]      mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_wr_n_q;
  logic                  mem_rd_n_q;
  logic                  if_ack_q;
  logic                  dt_ack_q;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic [DATA_WIDTH-1:0] dt_data_q;
  logic                  busy_q;
  logic                  grant_d;

  // Pick the winner: a lone requester wins, and a tie goes to the port not granted last.
  always_comb begin
    grant_d = dt_req_i;
    if (if_req_i && dt_req_i) begin
      grant_d = ~last_grant_q;
    end
  end

  // Arbitration FSM. All outputs are registered here.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wr_n_q   <= 1'b1;
      mem_rd_n_q   <= 1'b1;
      if_ack_q     <= 1'b0;
      dt_ack_q     <= 1'b0;
      if_data_q    <= '0;
      dt_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (if_req_i || dt_req_i) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= grant_d & dt_we_i;
            mem_addr_q   <= grant_d ? dt_addr_i : if_addr_i;
            if (grant_d && dt_we_i) begin
              mem_data_q <= dt_data_i;
              mem_wr_n_q <= 1'b0;
            end else begin
              mem_rd_n_q <= 1'b0;
            end
            busy_q  <= 1'b1;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // The memory registered its read data on the falling edge inside ACCESS.
          mem_rd_n_q <= 1'b1;
          mem_wr_n_q <= 1'b1;
          if (!we_q) begin
            if (grant_q) begin
              dt_data_q <= mem_data_i;
            end else begin
              if_data_q <= mem_data_i;
            end
          end
          if (grant_q) begin
            dt_ack_q <= 1'b1;
          end else begin
            if_ack_q <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          if_ack_q <= 1'b0;
          dt_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign if_ack_o   = if_ack_q;
  assign dt_ack_o   = dt_ack_q;
  assign if_data_o  = if_data_q;
  assign dt_data_o  = dt_data_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_wr_o   = mem_wr_n_q;
  assign mem_rd_o   = mem_rd_n_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction table, directed corner sequences,
// and random traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_ack_o;
  logic [DW-1:0] if_data_o;
  logic          dt_req_i = 1'b0;
  logic          dt_we_i = 1'b0;
  logic [AW-1:0] dt_addr_i = '0;
  logic [DW-1:0] dt_data_i = '0;
  logic          dt_ack_o;
  logic [DW-1:0] dt_data_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_wr_o;
  logic          mem_rd_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORDS(AW), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_data_o  (if_data_o),
    .dt_req_i   (dt_req_i),
    .dt_we_i    (dt_we_i),
    .dt_addr_i  (dt_addr_i),
    .dt_data_i  (dt_data_i),
    .dt_ack_o   (dt_ack_o),
    .dt_data_o  (dt_data_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_wr_o   (mem_wr_o),
    .mem_rd_o   (mem_rd_o),
    .mem_data_i (mem_data_i),
    .busy_o     (busy_o)
  );

  // Synchronous memory: writes and read-data capture happen on the falling edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(negedge clk) begin
    if (!mem_wr_o) mem[mem_addr_o] = mem_data_o;
    if (!mem_rd_o) mem_data_i = mem[mem_addr_o];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // These properties must hold in every scenario.
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("inv_both_acks", {63'b0, if_ack_o & dt_ack_o}, 64'd0);
      chk("inv_rd_and_wr", {63'b0, !mem_rd_o && !mem_wr_o}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i  = 1'b1;
    if_req_i = 1'b0;
    dt_req_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_if;
    logic [DW-1:0] exp_dt;
  } vec_t;

  // One complete transfer with cycle-exact checks of ACCESS, RESP and the return to IDLE.
  task automatic run_txn(input vec_t v);
    if (v.port) begin
      dt_req_i  = 1'b1;
      dt_we_i   = v.we;
      dt_addr_i = v.addr;
      dt_data_i = v.wdata;
    end else begin
      if_req_i  = 1'b1;
      if_addr_i = v.addr;
    end
    tick();
    chk("acc_busy", {63'b0, busy_o}, 64'd1);
    chk("acc_addr", {54'b0, mem_addr_o}, {54'b0, v.addr});
    chk("acc_rd_n", {63'b0, mem_rd_o}, {63'b0, v.we});
    chk("acc_wr_n", {63'b0, mem_wr_o}, {63'b0, !v.we});
    if (v.we) chk("acc_wdata", {32'b0, mem_data_o}, {32'b0, v.wdata});
    chk("acc_acks", {62'b0, if_ack_o, dt_ack_o}, 64'd0);
    tick();
    chk("rsp_if_ack", {63'b0, if_ack_o}, {63'b0, !v.port});
    chk("rsp_dt_ack", {63'b0, dt_ack_o}, {63'b0, v.port});
    chk("rsp_if_data", {32'b0, if_data_o}, {32'b0, v.exp_if});
    chk("rsp_dt_data", {32'b0, dt_data_o}, {32'b0, v.exp_dt});
    chk("rsp_enables", {62'b0, mem_rd_o, mem_wr_o}, 64'd3);
    if_req_i = 1'b0;
    dt_req_i = 1'b0;
    tick();
    chk("idle_acks", {62'b0, if_ack_o, dt_ack_o}, 64'd0);
    chk("idle_busy", {63'b0, busy_o}, 64'd0);
  endtask

  // Transaction-level reference model state for the random phase.
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  int            e, g, free_e;
  bit            last_port, g_port, g_read, win;
  logic [DW-1:0] g_rd, exp_if_d, exp_dt_d;
  bit            exp_if_ack, exp_dt_ack, exp_busy;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 10'h3FF, 32'h00000050, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 10'h3FF, 32'h0,        32'hDEADBEEF, 32'h00000050};
    vecs[3] = '{1'b0, 1'b0, 10'h3FF, 32'h0,        32'h00000050, 32'h00000050};
    vecs[4] = '{1'b1, 1'b1, 10'h000, 32'hA5A55A5A, 32'h00000050, 32'h00000050};
    vecs[5] = '{1'b0, 1'b0, 10'h000, 32'h0,        32'hA5A55A5A, 32'h00000050};
    vecs[6] = '{1'b1, 1'b0, 10'h010, 32'h0,        32'hA5A55A5A, 32'hDEADBEEF};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[10'h010] = 32'hDEADBEEF;

    // Reset state
    tick();
    tick();
    chk("rst_wr_n", {63'b0, mem_wr_o}, 64'd1);
    chk("rst_rd_n", {63'b0, mem_rd_o}, 64'd1);
    chk("rst_addr", {54'b0, mem_addr_o}, 64'd0);
    chk("rst_wdata", {32'b0, mem_data_o}, 64'd0);
    chk("rst_acks", {62'b0, if_ack_o, dt_ack_o}, 64'd0);
    chk("rst_if_data", {32'b0, if_data_o}, 64'd0);
    chk("rst_dt_data", {32'b0, dt_data_o}, 64'd0);
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    reset_i = 1'b0;
    tick();

    // Transaction table
    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Simultaneous requests after reset: grants alternate 0,1,0,1, with acks 3 cycles apart
    do_reset();
    if_req_i  = 1'b1;
    if_addr_i = 10'h010;
    dt_req_i  = 1'b1;
    dt_we_i   = 1'b0;
    dt_addr_i = 10'h3FF;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("rr_if_ack_%0d", k), {63'b0, if_ack_o}, {63'b0, k == 1 || k == 7});
      chk($sformatf("rr_dt_ack_%0d", k), {63'b0, dt_ack_o}, {63'b0, k == 4 || k == 10});
    end
    chk("rr_if_data", {32'b0, if_data_o}, {32'b0, 32'hDEADBEEF});
    chk("rr_dt_data", {32'b0, dt_data_o}, {32'b0, 32'h00000050});
    if_req_i = 1'b0;
    dt_req_i = 1'b0;
    tick();
    tick();

    // Reset during a write ACCESS, before the falling edge
    mem[10'h020] = 32'h12345678;
    dt_req_i  = 1'b1;
    dt_we_i   = 1'b1;
    dt_addr_i = 10'h020;
    dt_data_i = 32'hCAFEF00D;
    tick();
    chk("mid_pre_wr_n", {63'b0, mem_wr_o}, 64'd0);
    reset_i = 1'b1;
    #1;
    chk("mid_wr_n", {63'b0, mem_wr_o}, 64'd1);
    chk("mid_rd_n", {63'b0, mem_rd_o}, 64'd1);
    chk("mid_busy", {63'b0, busy_o}, 64'd0);
    dt_req_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_ack", {62'b0, if_ack_o, dt_ack_o}, 64'd0);
    end
    chk("mid_mem_kept", {32'b0, mem[10'h020]}, {32'b0, 32'h12345678});

    // Request withdrawn in ACCESS: the transfer still completes
    begin
      int busy_cnt, ack_cnt;
      busy_cnt  = 0;
      ack_cnt   = 0;
      dt_req_i  = 1'b1;
      dt_we_i   = 1'b0;
      dt_addr_i = 10'h010;
      tick();
      dt_req_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
        busy_cnt += int'(busy_o);
        ack_cnt  += int'(dt_ack_o);
        tick();
      end
      chk("wd_busy_cycles", 64'(busy_cnt), 64'd2);
      chk("wd_ack_pulses", 64'(ack_cnt), 64'd1);
      chk("wd_data", {32'b0, dt_data_o}, {32'b0, 32'hDEADBEEF});
    end

    // Random traffic against the transaction-level model
    reset_i = 1'b1;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]       = i * 32'h9E3779B1;
      model_mem[i] = i * 32'h9E3779B1;
    end
    do_reset();
    e = 0; g = -10; free_e = 0; last_port = 1'b1;
    g_port = 1'b0; g_read = 1'b0; g_rd = '0;
    exp_if_d = '0; exp_dt_d = '0;
    exp_if_ack = 1'b0; exp_dt_ack = 1'b0; exp_busy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_if_ack", {63'b0, if_ack_o}, {63'b0, exp_if_ack});
      chk("rnd_dt_ack", {63'b0, dt_ack_o}, {63'b0, exp_dt_ack});
      chk("rnd_busy", {63'b0, busy_o}, {63'b0, exp_busy});
      chk("rnd_if_data", {32'b0, if_data_o}, {32'b0, exp_if_d});
      chk("rnd_dt_data", {32'b0, dt_data_o}, {32'b0, exp_dt_d});
      if (exp_if_ack) if_req_i = 1'b0;
      if (exp_dt_ack) dt_req_i = 1'b0;
      @(posedge clk);
      e++;
      // A grant is possible only 3 edges after the previous one.
      if (e >= free_e && (if_req_i || dt_req_i)) begin
        win = (if_req_i && dt_req_i) ? !last_port : dt_req_i;
        last_port = win;
        g_port = win;
        g = e;
        free_e = e + 3;
        if (win && dt_we_i) begin
          model_mem[dt_addr_i] = dt_data_i;
          g_read = 1'b0;
        end else begin
          g_read = 1'b1;
          g_rd = model_mem[win ? dt_addr_i : if_addr_i];
        end
      end
      exp_busy   = (e == g) || (e == g + 1);
      exp_if_ack = (e == g + 1) && !g_port;
      exp_dt_ack = (e == g + 1) && g_port;
      if (e == g + 1 && g_read) begin
        if (g_port) exp_dt_d = g_rd;
        else exp_if_d = g_rd;
      end
      #1;
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i  = 1'b1;
        if_addr_i = AW'($urandom_range(0, 15));
      end
      if (!dt_req_i && $urandom_range(0, 2) == 0) begin
        dt_req_i  = 1'b1;
        dt_we_i   = 1'($urandom_range(0, 1));
        dt_addr_i = AW'($urandom_range(0, 15));
        dt_data_i = $urandom;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
